// File: rtl/vtb_fbuf_dma_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : vtb_fbuf_dma_reader_if
// Description : UFI-bus read-master signal bundle between the frame-buffer
//               DMA reader (master) and the RAM slave / arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vtb_fbuf_dma_reader_if #(
  parameter int pUsiBusWidth = 32,
  parameter int pUfiBusWidth = 16
);
  logic [pUsiBusWidth-1:0] oMUfiAdrs;
  logic                    oMUfiREd;
  logic                    oMUfiVd;
  logic                    oMUfiCmd;
  logic                    iMUfiRdy;
  logic [pUfiBusWidth-1:0] iMUfiRd;
  logic                    iMUfiREd;

  modport master (
    output oMUfiAdrs, oMUfiREd, oMUfiVd, oMUfiCmd,
    input  iMUfiRdy, iMUfiRd, iMUfiREd
  );

  modport slave (
    input  oMUfiAdrs, oMUfiREd, oMUfiVd, oMUfiCmd,
    output iMUfiRdy, iMUfiRd, iMUfiREd
  );
endinterface
`default_nettype wire

// File: rtl/vtb_fbuf_dma_reader.sv
`default_nettype none
// ============================================================================
// Module      : vtb_fbuf_dma_reader
// Description : Double-buffered frame-buffer read DMA. Issues burst reads on
//               the UFI bus and pushes returned pixels into the video output
//               FIFO, throttled by a credit count of free FIFO slots.
// Revision    : 1.0 - initial release
// ============================================================================
module vtb_fbuf_dma_reader #(
  parameter int pUsiBusWidth  = 32,
  parameter int pUfiBusWidth  = 16,
  parameter int pMemAdrsWidth = 19,
  parameter int pFifoDepth    = 1024,
  parameter int pBurstLen     = 16
) (
  input  logic                     iSCLK,
  input  logic                     iSRST,
  input  logic                     iDmaEn,
  input  logic                     iFrameStart,
  input  logic                     iFbufSel,
  input  logic [pMemAdrsWidth-1:0] iFbufAdrs1,
  input  logic [pMemAdrsWidth-1:0] iFbufAdrs2,
  input  logic [pMemAdrsWidth-1:0] iFbufLen,
  vtb_fbuf_dma_reader_if.master    ufi,
  output logic [pUfiBusWidth-1:0]  oFifoWd,
  output logic                     oFifoWe,
  input  logic                     iFifoRe,
  output logic                     oFrameDone,
  output logic                     oLateErr,
  input  logic                     iLateErrClr
);

  localparam int cCntWidth   = $clog2(pFifoDepth + 1);
  localparam int cBurstWidth = $clog2(pBurstLen + 1);
  localparam logic [cCntWidth-1:0]     cCreditMax = cCntWidth'(pFifoDepth);
  localparam logic [cCntWidth-1:0]     cCntOne    = cCntWidth'(1);
  localparam logic [cBurstWidth-1:0]   cBurstMax  = cBurstWidth'(pBurstLen);
  localparam logic [pMemAdrsWidth-1:0] cBurstLenA = pMemAdrsWidth'(pBurstLen);

  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sWait  = 3'd1,
    sReq   = 3'd2,
    sGap   = 3'd3,
    sDrain = 3'd4
  } tState;

  tState                    rState;
  tState                    wStateNext;
  logic [pMemAdrsWidth-1:0] rBase;
  logic [pMemAdrsWidth-1:0] rOffset;
  logic [pMemAdrsWidth-1:0] rRemain;
  logic [cBurstWidth-1:0]   rBurst;
  logic [cCntWidth-1:0]     rCredit;
  logic [cCntWidth-1:0]     rOutst;
  logic                     rAborted;
  logic                     rLateErr;
  logic                     rFrameDone;
  logic [pUfiBusWidth-1:0]  rFifoWd;
  logic                     rFifoWe;

  logic                     wReqEn;
  logic                     wIssue;
  logic                     wRetire;
  logic                     wStart;
  logic                     wLate;
  logic                     wAbort;
  logic                     wDrainDone;
  logic [pMemAdrsWidth-1:0] wAdrs;
  logic [pMemAdrsWidth-1:0] wNeed;
  logic [pMemAdrsWidth-1:0] wRemainNext;
  logic [cBurstWidth-1:0]   wBurstNext;
  logic [cCntWidth-1:0]     wCreditNext;
  logic [cCntWidth-1:0]     wOutstNext;

  // Strobe is withdrawn the moment the DMA is disabled so no read slips out.
  assign wReqEn      = (rState == sReq) && iDmaEn;
  assign wIssue      = wReqEn && ufi.iMUfiRdy;
  // Returns with nothing outstanding (e.g. stale data after reset) are dropped.
  assign wRetire     = ufi.iMUfiREd && (rOutst != '0);
  assign wStart      = iFrameStart && iDmaEn && (rState == sIdle);
  assign wLate       = iFrameStart && (rState != sIdle);
  assign wDrainDone  = (rState == sDrain) && (rOutst == '0);
  assign wAdrs       = rBase + rOffset;
  assign wNeed       = (rRemain >= cBurstLenA) ? cBurstLenA : rRemain;
  assign wRemainNext = rRemain - pMemAdrsWidth'(wIssue);
  assign wBurstNext  = rBurst + cBurstWidth'(wIssue);
  assign wOutstNext  = rOutst + cCntWidth'(wIssue) - cCntWidth'(wRetire);

  assign ufi.oMUfiAdrs = pUsiBusWidth'(wAdrs);
  assign ufi.oMUfiREd  = wReqEn;
  assign ufi.oMUfiVd   = (rState == sReq);
  assign ufi.oMUfiCmd  = 1'b1;
  assign oFifoWd       = rFifoWd;
  assign oFifoWe       = rFifoWe;
  assign oFrameDone    = rFrameDone;
  assign oLateErr      = rLateErr;

  // Credit update: an issue consumes a slot, a pop frees one, capped at depth.
  always_comb begin
    wCreditNext = rCredit;
    if (wIssue && !iFifoRe) begin
      wCreditNext = rCredit - cCntOne;
    end else if (!wIssue && iFifoRe && (rCredit != cCreditMax)) begin
      wCreditNext = rCredit + cCntOne;
    end
  end

  // Next-state decode; any state that could still issue falls to DRAIN on disable.
  always_comb begin
    wStateNext = rState;
    wAbort     = 1'b0;
    case (rState)
      sIdle: begin
        if (wStart) begin
          wStateNext = (iFbufLen == '0) ? sDrain : sWait;
        end
      end
      sWait: begin
        if (!iDmaEn) begin
          wStateNext = sDrain;
          wAbort     = 1'b1;
        end else if (32'(rCredit) >= 32'(wNeed)) begin
          wStateNext = sReq;
        end
      end
      sReq: begin
        if (!iDmaEn) begin
          wStateNext = sDrain;
          wAbort     = 1'b1;
        end else if ((wBurstNext == cBurstMax) || (wCreditNext == '0) ||
                     (wRemainNext == '0)) begin
          wStateNext = sGap;
        end
      end
      sGap: begin
        if (!iDmaEn) begin
          wStateNext = sDrain;
          wAbort     = 1'b1;
        end else begin
          wStateNext = (rRemain != '0) ? sWait : sDrain;
        end
      end
      sDrain: begin
        if (rOutst == '0) begin
          wStateNext = sIdle;
        end
      end
      default: wStateNext = sIdle;
    endcase
  end

  // State register.
  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      rState <= sIdle;
    end else begin
      rState <= wStateNext;
    end
  end

  // Per-frame address, length and burst bookkeeping.
  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      rBase    <= '0;
      rOffset  <= '0;
      rRemain  <= '0;
      rBurst   <= '0;
      rAborted <= 1'b0;
    end else if (wStart) begin
      rBase    <= iFbufSel ? iFbufAdrs2 : iFbufAdrs1;
      rOffset  <= '0;
      rRemain  <= iFbufLen;
      rBurst   <= '0;
      rAborted <= 1'b0;
    end else begin
      if (wIssue) begin
        rOffset <= rOffset + pMemAdrsWidth'(1);
        rRemain <= wRemainNext;
        rBurst  <= wBurstNext;
      end
      if (rState == sGap) begin
        rBurst <= '0;
      end
      if (wAbort) begin
        rAborted <= 1'b1;
      end
    end
  end

  // Credit and in-flight read counters.
  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      rCredit <= cCreditMax;
      rOutst  <= '0;
    end else begin
      rCredit <= wCreditNext;
      rOutst  <= wOutstNext;
    end
  end

  // Read data path: one register stage from the bus into the FIFO.
  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      rFifoWd <= '0;
      rFifoWe <= 1'b0;
    end else begin
      rFifoWd <= ufi.iMUfiRd;
      rFifoWe <= wRetire;
    end
  end

  // Status: frame-done pulse (not for aborted frames) and sticky late-start flag.
  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      rFrameDone <= 1'b0;
      rLateErr   <= 1'b0;
    end else begin
      rFrameDone <= wDrainDone && !rAborted;
      if (wLate) begin
        rLateErr <= 1'b1;
      end else if (iLateErrClr) begin
        rLateErr <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vtb_fbuf_dma_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vtb_fbuf_dma_reader
// Description : Directed self-checking bench for vtb_fbuf_dma_reader with a
//               one-cycle-latency RAM slave and a FIFO consumer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vtb_fbuf_dma_reader;

  localparam int cAw    = 19;
  localparam int cDepth = 32;

  logic wMemClk = 1'b0;
  always #5 wMemClk = ~wMemClk;

  logic             srst, dmaEn, frameStart, fbufSel, lateErrClr, fifoRe;
  logic [cAw-1:0]   fbufAdrs1, fbufAdrs2, fbufLen;
  logic [15:0]      fifoWd;
  logic             fifoWe, frameDone, lateErr;

  vtb_fbuf_dma_reader_if #(.pUsiBusWidth(32), .pUfiBusWidth(16)) ufiBus ();

  vtb_fbuf_dma_reader #(
    .pUsiBusWidth(32), .pUfiBusWidth(16), .pMemAdrsWidth(cAw),
    .pFifoDepth(cDepth), .pBurstLen(16)
  ) dut (
    .iSCLK(wMemClk), .iSRST(srst), .iDmaEn(dmaEn), .iFrameStart(frameStart),
    .iFbufSel(fbufSel), .iFbufAdrs1(fbufAdrs1), .iFbufAdrs2(fbufAdrs2),
    .iFbufLen(fbufLen), .ufi(ufiBus), .oFifoWd(fifoWd), .oFifoWe(fifoWe),
    .iFifoRe(fifoRe), .oFrameDone(frameDone), .oLateErr(lateErr),
    .iLateErrClr(lateErrClr)
  );

  int total = 0;
  int bad   = 0;
  int rdyMode, popEn, popBudget, extraPops, fifoCnt, doneCnt, vdCycles, curBurst;
  logic        prevVd, pend;
  logic [31:0] pendAdrs;
  logic [31:0] issueQ[$];
  logic [15:0] writeQ[$];
  int          burstQ[$];

  // RAM contents as seen by the slave model.
  function automatic logic [15:0] memData(input logic [31:0] a);
    return {a[3:0], a[15:4]} ^ 16'h5A5A ^ {13'd0, a[18:16]};
  endfunction

  // Slave, consumer and observer; everything happens on the falling edge.
  initial begin
    ufiBus.iMUfiRdy = 1'b1; ufiBus.iMUfiREd = 1'b0; ufiBus.iMUfiRd = '0;
    fifoRe = 1'b0; rdyMode = 0; popEn = 1; popBudget = 0; extraPops = 0;
    fifoCnt = 0; doneCnt = 0; vdCycles = 0; curBurst = 0;
    prevVd = 1'b0; pend = 1'b0; pendAdrs = '0;
    forever begin
      @(negedge wMemClk);
      ufiBus.iMUfiRdy = (rdyMode == 1) ? ~ufiBus.iMUfiRdy : 1'b1;
      ufiBus.iMUfiREd = pend;
      ufiBus.iMUfiRd  = pend ? memData(pendAdrs) : 16'h0000;
      if (extraPops > 0) begin
        fifoRe = 1'b1; extraPops--;
      end else if (fifoCnt > 0 && (popEn != 0 || popBudget > 0)) begin
        fifoRe = 1'b1; fifoCnt--;
        if (popEn == 0) popBudget--;
      end else begin
        fifoRe = 1'b0;
      end
      if (fifoWe) begin
        fifoCnt++; writeQ.push_back(fifoWd);
      end
      if (ufiBus.oMUfiREd && ufiBus.iMUfiRdy) begin
        issueQ.push_back(ufiBus.oMUfiAdrs);
        pend = 1'b1; pendAdrs = ufiBus.oMUfiAdrs; curBurst++;
      end else begin
        pend = 1'b0;
      end
      if (ufiBus.oMUfiVd) vdCycles++;
      if (prevVd && !ufiBus.oMUfiVd) begin
        burstQ.push_back(curBurst); curBurst = 0;
      end
      prevVd = ufiBus.oMUfiVd;
      if (frameDone) doneCnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge wMemClk);
    #1;
  endtask

  task automatic clearStats();
    issueQ.delete(); writeQ.delete(); burstQ.delete();
    doneCnt = 0; vdCycles = 0; curBurst = 0;
  endtask

  task automatic startFrame(input logic sel, input logic [cAw-1:0] a1,
                            input logic [cAw-1:0] a2, input logic [cAw-1:0] len);
    fbufSel = sel; fbufAdrs1 = a1; fbufAdrs2 = a2; fbufLen = len;
    frameStart = 1'b1;
    cyc(1);
    frameStart = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc, input string tag);
    int n = 0;
    while (doneCnt == 0 && n < maxCyc) begin cyc(1); n++; end
    total++;
    if (doneCnt == 0) begin
      bad++; $display("FAIL %s_timeout: oFrameDone count got=0 want>=1 within %0d cycles", tag, maxCyc);
    end
  endtask

  task automatic waitIssues(input int cnt, input int maxCyc, input string tag);
    int n = 0;
    while (issueQ.size() < cnt && n < maxCyc) begin cyc(1); n++; end
    total++;
    if (issueQ.size() < cnt) begin
      bad++; $display("FAIL %s_timeout: issues got=%0d want=%0d", tag, issueQ.size(), cnt);
    end
  endtask

  task automatic test_reset();
    total++; if (ufiBus.oMUfiVd !== 1'b0) begin bad++; $display("FAIL rst_vd got=%b want=0", ufiBus.oMUfiVd); end
    total++; if (ufiBus.oMUfiREd !== 1'b0) begin bad++; $display("FAIL rst_red got=%b want=0", ufiBus.oMUfiREd); end
    total++; if (ufiBus.oMUfiCmd !== 1'b1) begin bad++; $display("FAIL rst_cmd got=%b want=1", ufiBus.oMUfiCmd); end
    total++; if (ufiBus.oMUfiAdrs !== 32'd0) begin bad++; $display("FAIL rst_adrs got=%h want=0", ufiBus.oMUfiAdrs); end
    total++; if (fifoWe !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", fifoWe); end
    total++; if (frameDone !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", frameDone); end
    total++; if (lateErr !== 1'b0) begin bad++; $display("FAIL rst_late got=%b want=0", lateErr); end
  endtask

  task automatic test_basic_frame();
    int errs = 0;
    clearStats(); popEn = 1; rdyMode = 0;
    startFrame(1'b0, 19'd0, 19'd0, 19'd100);
    waitDone(1000, "basic");
    cyc(4);
    total++; if (issueQ.size() !== 100) begin bad++; $display("FAIL basic_issues got=%0d want=100", issueQ.size()); end
    foreach (issueQ[i]) if (issueQ[i] !== 32'(i)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL basic_adrs_seq got=%0d bad addresses want=0", errs); end
    total++; if (writeQ.size() !== 100) begin bad++; $display("FAIL basic_writes got=%0d want=100", writeQ.size()); end
    errs = 0;
    foreach (writeQ[i]) if (writeQ[i] !== memData(32'(i))) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL basic_data got=%0d bad words want=0", errs); end
    total++; if (doneCnt !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", doneCnt); end
    errs = 0;
    foreach (burstQ[i]) if (burstQ[i] !== ((i == 6) ? 4 : 16)) errs++;
    total++; if (burstQ.size() !== 7 || errs !== 0) begin
      bad++; $display("FAIL basic_bursts got=%0d bursts/%0d wrong want=7/0", burstQ.size(), errs);
    end
  endtask

  task automatic test_buffer_toggle();
    int errs = 0;
    clearStats();
    startFrame(1'b1, 19'd0, 19'd27200, 19'd27200);
    waitDone(40000, "toggle");
    cyc(4);
    total++; if (issueQ.size() !== 27200) begin bad++; $display("FAIL toggle_issues got=%0d want=27200", issueQ.size()); end
    total++; if (issueQ[0] !== 32'd27200) begin bad++; $display("FAIL toggle_first got=%0d want=27200", issueQ[0]); end
    total++; if (issueQ[$] !== 32'd54399) begin bad++; $display("FAIL toggle_last got=%0d want=54399", issueQ[$]); end
    foreach (issueQ[i]) if (issueQ[i] !== 32'(27200 + i)) errs++;
    foreach (writeQ[i]) if (writeQ[i] !== memData(32'(27200 + i))) errs++;
    total++; if (errs !== 0 || writeQ.size() !== 27200) begin
      bad++; $display("FAIL toggle_stream got=%0d errors/%0d writes want=0/27200", errs, writeQ.size());
    end
    total++; if (doneCnt !== 1) begin bad++; $display("FAIL toggle_done got=%0d want=1", doneCnt); end
  endtask

  task automatic test_credit_stall();
    int errs = 0;
    clearStats(); popEn = 0; fifoCnt = 0;
    extraPops = 16;
    cyc(20);
    startFrame(1'b0, 19'd1000, 19'd0, 19'd100);
    cyc(80);
    total++; if (issueQ.size() !== 32) begin bad++; $display("FAIL credit_stall_issues got=%0d want=32", issueQ.size()); end
    total++; if (ufiBus.oMUfiVd !== 1'b0) begin bad++; $display("FAIL credit_stall_vd got=%b want=0", ufiBus.oMUfiVd); end
    popBudget = 16;
    cyc(80);
    total++; if (issueQ.size() !== 48) begin bad++; $display("FAIL credit_refill_issues got=%0d want=48", issueQ.size()); end
    popEn = 1;
    waitDone(2000, "credit");
    cyc(4);
    total++; if (issueQ.size() !== 100) begin bad++; $display("FAIL credit_total got=%0d want=100", issueQ.size()); end
    foreach (issueQ[i]) if (issueQ[i] !== 32'(1000 + i)) errs++;
    foreach (writeQ[i]) if (writeQ[i] !== memData(32'(1000 + i))) errs++;
    total++; if (errs !== 0 || writeQ.size() !== 100) begin
      bad++; $display("FAIL credit_stream got=%0d errors/%0d writes want=0/100", errs, writeQ.size());
    end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    clearStats(); popEn = 1; rdyMode = 1;
    startFrame(1'b0, 19'd500, 19'd0, 19'd50);
    waitDone(1000, "bp");
    cyc(4);
    rdyMode = 0;
    total++; if (issueQ.size() !== 50) begin bad++; $display("FAIL bp_issues got=%0d want=50", issueQ.size()); end
    foreach (issueQ[i]) if (issueQ[i] !== 32'(500 + i)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_adrs_seq got=%0d bad addresses want=0", errs); end
    errs = 0;
    foreach (writeQ[i]) if (writeQ[i] !== memData(32'(500 + i))) errs++;
    total++; if (writeQ.size() !== 50 || errs !== 0) begin
      bad++; $display("FAIL bp_writes got=%0d writes/%0d errors want=50/0", writeQ.size(), errs);
    end
    total++; if (doneCnt !== 1) begin bad++; $display("FAIL bp_done got=%0d want=1", doneCnt); end
  endtask

  task automatic test_late_abort();
    int errs = 0;
    clearStats(); popEn = 1;
    startFrame(1'b0, 19'd2000, 19'd9000, 19'd100);
    waitIssues(10, 100, "late");
    fbufSel = 1'b1; frameStart = 1'b1; lateErrClr = 1'b1;
    cyc(1);
    frameStart = 1'b0; lateErrClr = 1'b0;
    total++; if (lateErr !== 1'b1) begin bad++; $display("FAIL late_set_wins got=%b want=1", lateErr); end
    waitIssues(40, 200, "abort");
    dmaEn = 1'b0;
    cyc(30);
    total++; if (issueQ.size() !== 40) begin bad++; $display("FAIL abort_issues got=%0d want=40", issueQ.size()); end
    foreach (issueQ[i]) if (issueQ[i] !== 32'(2000 + i)) errs++;
    foreach (writeQ[i]) if (writeQ[i] !== memData(32'(2000 + i))) errs++;
    total++; if (errs !== 0 || writeQ.size() !== 40) begin
      bad++; $display("FAIL abort_stream got=%0d errors/%0d writes want=0/40", errs, writeQ.size());
    end
    total++; if (doneCnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", doneCnt); end
    total++; if (lateErr !== 1'b1) begin bad++; $display("FAIL late_sticky got=%b want=1", lateErr); end
    lateErrClr = 1'b1;
    cyc(1);
    lateErrClr = 1'b0; dmaEn = 1'b1;
    total++; if (lateErr !== 1'b0) begin bad++; $display("FAIL late_clear got=%b want=0", lateErr); end
    startFrame(1'b0, 19'd0, 19'd0, 19'd0);
    waitDone(10, "idle_after_abort");
    total++; if (lateErr !== 1'b0) begin bad++; $display("FAIL idle_after_abort_late got=%b want=0", lateErr); end
  endtask

  task automatic test_edge_cases();
    int errs = 0;
    int wBefore, iBefore;
    // Empty frame: done pulse on the second edge after the start, no bus request.
    cyc(4); clearStats();
    fbufLen = '0; frameStart = 1'b1;
    cyc(1);
    frameStart = 1'b0;
    total++; if (frameDone !== 1'b0) begin bad++; $display("FAIL empty_done_early got=%b want=0", frameDone); end
    cyc(1);
    total++; if (frameDone !== 1'b1) begin bad++; $display("FAIL empty_done got=%b want=1", frameDone); end
    cyc(1);
    total++; if (frameDone !== 1'b0) begin bad++; $display("FAIL empty_done_pulse got=%b want=0", frameDone); end
    total++; if (vdCycles !== 0) begin bad++; $display("FAIL empty_vd got=%0d cycles want=0", vdCycles); end
    // Address wrap at the top of RAM.
    clearStats();
    startFrame(1'b0, 19'h7FFF8, 19'd0, 19'd16);
    waitDone(200, "wrap");
    cyc(4);
    foreach (issueQ[i]) if (issueQ[i] !== ((32'h7FFF8 + 32'(i)) & 32'h7FFFF)) errs++;
    total++; if (issueQ.size() !== 16 || errs !== 0) begin
      bad++; $display("FAIL wrap_adrs got=%0d issues/%0d errors want=16/0", issueQ.size(), errs);
    end
    total++; if (issueQ[8] !== 32'h0) begin bad++; $display("FAIL wrap_point got=%h want=00000000", issueQ[8]); end
    // Asynchronous reset in the middle of a burst.
    clearStats();
    startFrame(1'b0, 19'd3000, 19'd0, 19'd100);
    waitIssues(5, 100, "rst_mid");
    #2 srst = 1'b1;
    #1;
    total++; if (ufiBus.oMUfiVd !== 1'b0 || ufiBus.oMUfiREd !== 1'b0) begin
      bad++; $display("FAIL rst_mid_bus got=vd%b/red%b want=0/0", ufiBus.oMUfiVd, ufiBus.oMUfiREd);
    end
    total++; if (ufiBus.oMUfiAdrs !== 32'd0) begin bad++; $display("FAIL rst_mid_adrs got=%h want=0", ufiBus.oMUfiAdrs); end
    total++; if (fifoWe !== 1'b0) begin bad++; $display("FAIL rst_mid_we got=%b want=0", fifoWe); end
    total++; if (ufiBus.oMUfiCmd !== 1'b1) begin bad++; $display("FAIL rst_mid_cmd got=%b want=1", ufiBus.oMUfiCmd); end
    cyc(2);
    total++; if (fifoWe !== 1'b0) begin bad++; $display("FAIL rst_hold_we got=%b want=0", fifoWe); end
    srst = 1'b0; fifoCnt = 0;
    wBefore = writeQ.size(); iBefore = issueQ.size();
    cyc(6);
    total++; if (writeQ.size() !== wBefore || issueQ.size() !== iBefore) begin
      bad++; $display("FAIL rst_quiet got=%0d/%0d want=%0d/%0d", writeQ.size(), issueQ.size(), wBefore, iBefore);
    end
    total++; if (ufiBus.oMUfiVd !== 1'b0) begin bad++; $display("FAIL rst_idle_vd got=%b want=0", ufiBus.oMUfiVd); end
  endtask

  initial begin
    srst = 1'b1; dmaEn = 1'b1; frameStart = 1'b0; fbufSel = 1'b0; lateErrClr = 1'b0;
    fbufAdrs1 = '0; fbufAdrs2 = '0; fbufLen = '0;
    cyc(3);
    test_reset();
    srst = 1'b0;
    cyc(2);
    test_basic_frame();
    test_buffer_toggle();
    test_credit_stall();
    test_backpressure();
    test_late_abort();
    test_edge_cases();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
